// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter with bounded locking for the single-port data memory
//
// Grants one access per cycle to master 0 (processor) or master 1 (debug/DMA),
// checks the address range/alignment, drives the memory port and routes the
// one-cycle-latency response back to the master that issued it.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   mx_req/we/addr/     master x request and payload (held until mx_gnt)
//   mx_wdata/wstrb/lock
//   mx_gnt              combinational grant for this cycle
//   mx_rvalid/rdata/err response for the access granted in the previous cycle
//   mem_en/we/addr/     memory command (word index), all zero when idle
//   mem_wdata/wstrb
//   mem_rdata           memory read data, valid the cycle after a read
module dmem_arbiter #(
  parameter int DMEM_SIZE_IN_BYTES = 2048,
  parameter int LOCK_MAX           = 8,
  localparam int AW                = $clog2(DMEM_SIZE_IN_BYTES) - 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          last;
  logic          lock_valid;
  logic          lock_owner;
  logic [CW-1:0] lock_cnt;

  logic          rsp_valid;
  logic          rsp_owner;
  logic          rsp_we;
  logic          rsp_err;

  logic          gnt_any;
  logic          win;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          sel_lock;
  logic          addr_err;
  logic [CW-1:0] cnt_inc;
  logic          good_read;

  // Winner selection. A lock only holds while its owner keeps requesting;
  // otherwise the pair falls back to "whoever was not granted last".
  always_comb begin
    gnt_any = 1'b0;
    win     = 1'b0;
    if (reset) begin
      if (lock_valid && (lock_owner ? m1_req : m0_req)) begin
        gnt_any = 1'b1;
        win     = lock_owner;
      end else if (m0_req && m1_req) begin
        gnt_any = 1'b1;
        win     = ~last;
      end else if (m0_req) begin
        gnt_any = 1'b1;
        win     = 1'b0;
      end else if (m1_req) begin
        gnt_any = 1'b1;
        win     = 1'b1;
      end
    end
  end

  assign m0_gnt    = gnt_any & ~win;
  assign m1_gnt    = gnt_any & win;

  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_wdata = win ? m1_wdata : m0_wdata;
  assign sel_wstrb = win ? m1_wstrb : m0_wstrb;
  assign sel_lock  = win ? m1_lock  : m0_lock;

  assign addr_err  = (sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(DMEM_SIZE_IN_BYTES));

  // An erroring access is still granted (so the master gets its error
  // response) but never reaches the memory.
  assign mem_en    = gnt_any & ~addr_err;
  assign mem_we    = mem_en & sel_we;
  assign mem_addr  = gnt_any ? sel_addr[AW+1:2] : '0;
  assign mem_wdata = gnt_any ? sel_wdata : '0;
  assign mem_wstrb = mem_we ? sel_wstrb : 4'h0;

  // Consecutive locked grants by the same master; a fresh lock starts at 1.
  assign cnt_inc   = ((lock_valid && (lock_owner == win)) ? lock_cnt : '0) + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last       <= 1'b1;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= gnt_any;
      if (gnt_any) begin
        rsp_owner <= win;
        rsp_we    <= sel_we;
        rsp_err   <= addr_err;
        last      <= win;
      end
      // Reaching LOCK_MAX releases the lock with last = owner, so the other
      // master wins the next conflict. Idle cycles or an unlocked grant also
      // release it.
      if (gnt_any && sel_lock && (cnt_inc != CW'(LOCK_MAX))) begin
        lock_valid <= 1'b1;
        lock_owner <= win;
        lock_cnt   <= cnt_inc;
      end else begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end

  assign good_read = ~rsp_we & ~rsp_err;

  assign m0_rvalid = reset & rsp_valid & ~rsp_owner;
  assign m1_rvalid = reset & rsp_valid & rsp_owner;
  assign m0_rdata  = (m0_rvalid & good_read) ? mem_rdata : 32'h0;
  assign m1_rdata  = (m1_rvalid & good_read) ? mem_rdata : 32'h0;
  assign m0_err    = m0_rvalid & rsp_err;
  assign m1_err    = m1_rvalid & rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking testbench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int DMEM = 2048;
  localparam int LMAX = 8;
  localparam int AW   = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_SIZE_IN_BYTES(DMEM), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Data memory attached to the arbiter's memory port.
  logic [31:0] dmem [512];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) dmem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= dmem[mem_addr];
      end
    end
  end

  // Reference model state
  bit          m_last;
  bit          lk_v;
  int          lk_o;
  int          lk_cnt;
  bit          pv;
  int          po;
  bit          pe;
  logic [31:0] prd;
  logic [31:0] refmem [512];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    lk_v   = 1'b0;
    lk_o   = 0;
    lk_cnt = 0;
    pv     = 1'b0;
    po     = 0;
    pe     = 1'b0;
    prd    = 32'h0;
    for (int i = 0; i < 512; i++) refmem[i] = 32'h0;
  endtask

  // Compare all outputs at the falling edge, then advance the model to the
  // state it should hold after the coming rising edge.
  task automatic sample();
    bit          rq [2];
    bit          wq [2];
    bit          lq [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  st [2];
    int          w;
    bit          e;
    int          cnt;
    int          idx;
    @(negedge clk);
    if (!reset) begin
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_m0_err", m0_err, 0);
      chk("rst_m1_err", m1_err, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      model_reset();
      return;
    end
    rq[0] = m0_req;  rq[1] = m1_req;
    wq[0] = m0_we;   wq[1] = m1_we;
    lq[0] = m0_lock; lq[1] = m1_lock;
    ad[0] = m0_addr; ad[1] = m1_addr;
    wd[0] = m0_wdata; wd[1] = m1_wdata;
    st[0] = m0_wstrb; st[1] = m1_wstrb;

    chk("m0_rvalid", m0_rvalid, pv && po == 0);
    chk("m1_rvalid", m1_rvalid, pv && po == 1);
    chk("m0_rdata", m0_rdata, (pv && po == 0) ? prd : 32'h0);
    chk("m1_rdata", m1_rdata, (pv && po == 1) ? prd : 32'h0);
    chk("m0_err", m0_err, pv && po == 0 && pe);
    chk("m1_err", m1_err, pv && po == 1 && pe);

    w = -1;
    if (lk_v && rq[lk_o]) w = lk_o;
    else if (rq[0] && rq[1]) w = m_last ? 0 : 1;
    else if (rq[0]) w = 0;
    else if (rq[1]) w = 1;

    chk("m0_gnt", m0_gnt, w == 0);
    chk("m1_gnt", m1_gnt, w == 1);

    if (w < 0) begin
      chk("idle_mem_en", mem_en, 0);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_mem_addr", 32'(mem_addr), 0);
      chk("idle_mem_wdata", mem_wdata, 0);
      chk("idle_mem_wstrb", mem_wstrb, 0);
      pv     = 1'b0;
      lk_v   = 1'b0;
      lk_cnt = 0;
    end else begin
      e   = (ad[w][1:0] != 2'b00) || (ad[w] >= 32'(DMEM));
      idx = int'(ad[w][10:2]);
      chk("mem_en", mem_en, !e);
      if (!e) begin
        chk("mem_we", mem_we, wq[w]);
        chk("mem_addr", 32'(mem_addr), 32'(idx));
        if (wq[w]) begin
          chk("mem_wdata", mem_wdata, wd[w]);
          chk("mem_wstrb", mem_wstrb, st[w]);
        end else begin
          chk("mem_wstrb_rd", mem_wstrb, 0);
        end
      end
      pv  = 1'b1;
      po  = w;
      pe  = e;
      prd = (!wq[w] && !e) ? refmem[idx] : 32'h0;
      if (wq[w] && !e)
        for (int b = 0; b < 4; b++)
          if (st[w][b]) refmem[idx][8*b +: 8] = wd[w][8*b +: 8];
      m_last = (w == 1);
      if (lq[w]) begin
        cnt = (lk_v && lk_o == w) ? lk_cnt + 1 : 1;
        if (cnt >= LMAX) begin
          lk_v   = 1'b0;
          lk_cnt = 0;
        end else begin
          lk_v   = 1'b1;
          lk_o   = w;
          lk_cnt = cnt;
        end
      end else begin
        lk_v   = 1'b0;
        lk_cnt = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; m1_lock = 0;
  endtask

  task automatic m0_set(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit lk);
    m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_lock = lk;
  endtask

  task automatic m1_set(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit lk);
    m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_lock = lk;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    m0_req = 1;
    m1_req = 1;
    model_reset();
    sample();
    adv();
    reset = 1;
    idle();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'(DMEM + $urandom_range(0, 255) * 4);
    if (r == 2) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    reset = 0;
    idle();
    model_reset();
    adv();
    do_reset();

    // Solo write then read by m0
    m0_set(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    sample();
    chk("solo_wr_gnt", m0_gnt, 1);
    chk("solo_wr_addr", 32'(mem_addr), 4);
    adv();
    idle();
    m0_set(0, 32'h10, 0, 0, 0);
    sample();
    chk("solo_wr_rvalid", m0_rvalid, 1);
    adv();
    idle();
    sample();
    chk("solo_rd_rvalid", m0_rvalid, 1);
    chk("solo_rd_rdata", m0_rdata, 32'hDEADBEEF);
    adv();

    // Conflict right after reset alternates starting with m0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        m0_set(0, 32'h0, 0, 0, 0);
        m1_set(0, 32'h4, 0, 0, 0);
      end else begin
        idle();
      end
      sample();
      if (i < 4) chk("conf_gnt0", m0_gnt, (i % 2) == 0);
      if (i > 0) begin
        chk("conf_rv0", m0_rvalid, ((i - 1) % 2) == 0);
        chk("conf_rv1", m1_rvalid, ((i - 1) % 2) == 1);
      end
      adv();
    end

    // Lock bounded by LOCK_MAX
    do_reset();
    for (int i = 0; i < 12; i++) begin
      m0_set(0, 32'h8, 0, 0, 0);
      m1_set(0, 32'hC, 0, 0, 1);
      sample();
      chk("lock_gnt1", m1_gnt, (i != 0) && (i != 9));
      adv();
    end
    idle();
    sample();
    adv();

    // Address errors
    m0_set(0, 32'h802, 0, 0, 0);
    sample();
    chk("err_mis_gnt", m0_gnt, 1);
    chk("err_mis_en", mem_en, 0);
    adv();
    m0_set(0, 32'h800, 0, 0, 0);
    sample();
    chk("err_oor_en", mem_en, 0);
    chk("err_mis_rsp", m0_err, 1);
    chk("err_mis_rdata", m0_rdata, 0);
    adv();
    idle();
    sample();
    chk("err_oor_rv", m0_rvalid, 1);
    chk("err_oor_rsp", m0_err, 1);
    adv();

    // Partial write
    m1_set(1, 32'h0, 32'h11223344, 4'hF, 0);
    sample();
    adv();
    m1_set(1, 32'h0, 32'hAABBCCDD, 4'h3, 0);
    sample();
    adv();
    m1_set(0, 32'h0, 0, 0, 0);
    sample();
    adv();
    idle();
    sample();
    chk("pwr_rdata", m1_rdata, 32'h1122CCDD);
    adv();

    // Reset asserted while an m1 read is in flight
    m1_set(0, 32'h4, 0, 0, 0);
    sample();
    chk("rstmid_gnt", m1_gnt, 1);
    #1;
    reset = 0;
    idle();
    model_reset();
    adv();
    sample();
    chk("rstmid_rv_in", m1_rvalid, 0);
    adv();
    reset = 1;
    sample();
    chk("rstmid_rv_out", m1_rvalid, 0);
    adv();
    m0_set(0, 32'h0, 0, 0, 0);
    m1_set(0, 32'h0, 0, 0, 0);
    sample();
    chk("rstmid_conf", m0_gnt, 1);
    adv();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        m0_set($urandom_range(0, 1) == 1, rand_addr(), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 6)
        m1_set($urandom_range(0, 1) == 1, rand_addr(), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3) == 0);
      sample();
      adv();
    end
    idle();
    sample();
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory of the SoC between two requesters: the processor load/store port (master 0) and a debug/DMA loader port (master 1). Grants one access per cycle with round-robin fairness, bounded bus locking and address-range checking. Drives the memory's enable, write and strobe signals. Routes each one-cycle-latency response back to the master that issued it. Sits between `processor_0`/debug logic and `dmem_0` inside `SoC`.

## Interface
Parameters:
- `DMEM_SIZE_IN_BYTES`, 2048: byte size of the data memory; legal addresses are 0 .. `DMEM_SIZE_IN_BYTES`-4.
- `LOCK_MAX`, 8: maximum consecutive cycles one master may hold a lock before forced release.

Ports (x = 0, 1):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mx_req`  in  1  master x requests an access this cycle.
- `mx_we`  in  1  1 = write, 0 = read.
- `mx_addr`  in  32  byte address.
- `mx_wdata`  in  32  write data.
- `mx_wstrb`  in  4  byte-lane write enables.
- `mx_lock`  in  1  keep grant next cycle (sampled only when granted).
- `mx_gnt`  out  1  request accepted this cycle (combinational).
- `mx_rvalid`  out  1  response for the access granted the previous cycle.
- `mx_rdata`  out  32  read data; 0 for writes and errors.
- `mx_err`  out  1  qualifies `mx_rvalid`: the access was out of range or misaligned.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  `$clog2(DMEM_SIZE_IN_BYTES)-2`  word index = `addr[..:2]`.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  byte enables; 0 on reads.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_en` with `mem_we`=0.

## Operation
- At most one master granted per cycle. Grant is a combinational function of the `req` inputs and the registered state `last` (last granted master), `owner_lock`, `lock_cnt`.
- Arbitration:
  - Only one `req` high: that master wins.
  - Both high and no active lock: the master ≠ `last` wins.
  - Active lock held by master y: y wins if `y_req`. If y does not request, the lock drops and normal arbitration applies.
- Lock:
  - Set when the granted master has `lock`=1.
  - `lock_cnt` increments on each granted locked cycle.
  - When `lock_cnt` reaches `LOCK_MAX`, the lock clears and `last` = lock owner, so the other master wins any conflict next cycle.
  - `lock_cnt` clears whenever the lock clears.
- Address check: error if `addr[1:0]`≠0 or `addr` ≥ `DMEM_SIZE_IN_BYTES`. An erroring access is still granted, but `mem_en` stays 0.
- Memory drive:
  - `mem_en` = grant & !error.
  - `mem_*` fields are muxed from the winner.
  - When idle, all `mem_*` = 0.
- Response:
  - Register `rsp_owner`, `rsp_valid`, `rsp_we`, `rsp_err` on every grant.
  - Next cycle, the owner sees `rvalid`=1.
  - `rdata` = `mem_rdata` for a good read, else 0.
  - The non-owner sees `rvalid`=0 and `rdata`=0.
- Simultaneous events: a new grant in the same cycle as a response is legal, giving full throughput of 1 access/cycle.

## Timing
- Reset (`reset`=0, async): `rsp_valid`=0, `last`=1 (master 0 wins the first conflict), lock cleared, `lock_cnt`=0.
- During reset: all `gnt`, `rvalid`, `err` = 0; `rdata` = 0; `mem_en`/`mem_we` = 0.
- Reset asserted mid-access: the pending response is dropped and no `rvalid` is issued after release.
- Latency: `gnt` in cycle N, `rvalid`/`rdata`/`err` in cycle N+1. Writes commit to memory at the end of cycle N.
- Requesters hold `req` and payload until they see `gnt`. A `req` that drops before grant is legal and leaves no state behind.
- `last` updates on every grant. It does not change in idle cycles.

## Test plan
- Solo traffic: m0 writes 0xDEADBEEF to 0x10 (`wstrb`=0xF) → `m0_gnt` same cycle, `mem_addr`=4, `m0_rvalid` next cycle. m0 then reads 0x10 → `m0_rdata`=0xDEADBEEF one cycle after grant.
- Conflict after reset: both request continuously for 4 cycles → grants alternate m0, m1, m0, m1. Each `rvalid` lands only on the matching master one cycle later.
- Lock: m1 requests with `lock`=1 for 12 cycles while m0 requests continuously (`LOCK_MAX`=8) → m1 granted 8 consecutive cycles, then m0 granted once, then m1 reacquires.
- Errors: m0 reads 0x802, then 0x800 (`DMEM_SIZE_IN_BYTES`=2048) → `mem_en`=0 in both grant cycles. Next cycle: `m0_rvalid`=1, `m0_err`=1, `m0_rdata`=0.
- Partial write: preload word 0 = 0x11223344, m1 writes 0xAABBCCDD with `wstrb`=0x3, then reads → 0x1122CCDD.
- Reset mid-access: grant an m1 read, then drop `reset` before the next edge → `m1_rvalid` never asserts. After release, the first conflict goes to m0.
